pc_redirect_unit: RTL

// - IF-stage consumer of the ID-stage branch decision (Branch/taken pair from the branch comparator).
// - Owns the PC register, computes bne/j targets, redirects fetch and flushes IF/ID on taken branches.
// - Remembers a redirect that arrives while instruction memory is busy, and keeps branch statistics counters.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_redirect_unit_if.sv | 33 +++
 rtl/branch_target_calc.sv | 30 +++
 rtl/pc_redirect_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, IF-stage redirect states and reset PC.
// Also used by the branch comparator and the decoder.
package mips_pkg;

    localparam logic [5:0]  OP_BNE           = 6'b000101;
    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// IF-stage redirect bus: ID branch decision and hazard/memory status in, fetch PC and flush control out.
// IMemReady acts as the ready of the fetch at PC; BranchValid qualifies BranchTaken and is only consumed when Stall=0 in RUN.
interface pc_redirect_unit_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    logic             Stall;
    logic             IMemReady;
    logic             BranchValid;
    logic             BranchTaken;
    logic [31:0]      ID_Instruction;
    logic [31:0]      ID_PCPlus4;
    logic [31:0]      PC;
    logic [31:0]      PCPlus4;
    logic             Flush_IFID;
    logic             Redirect;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] TakenCount;
    logic             Err;
    state_t           State;

    modport master (
        output Stall, IMemReady, BranchValid, BranchTaken, ID_Instruction, ID_PCPlus4,
        input  PC, PCPlus4, Flush_IFID, Redirect, BranchCount, TakenCount, Err, State
    );

    modport slave (
        input  Stall, IMemReady, BranchValid, BranchTaken, ID_Instruction, ID_PCPlus4,
        output PC, PCPlus4, Flush_IFID, Redirect, BranchCount, TakenCount, Err, State
    );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational bne/j target computation from the instruction in ID and its PC+4.
module branch_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        target_valid
);

    logic [5:0] opcode;
    assign opcode = instruction[31:26];

    always_comb begin
        target       = '0;
        target_valid = 1'b0;
        case (opcode)
            OP_BNE: begin
                target       = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
                target_valid = 1'b1;
            end
            OP_J: begin
                target       = {pc_plus4[31:28], instruction[25:0], 2'b00};
                target_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// IF-stage PC owner: steps the fetch address, redirects on taken bne/j, holds a redirect
// while instruction memory is busy, and keeps saturating branch statistics.
module pc_redirect_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input logic               Clk,
    input logic               Rst_n,
    pc_redirect_unit_if.slave bus
);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] br_cnt_q, tk_cnt_q;
    logic             err_q, err_d;
    logic             flush_c, redirect_c;
    logic             accepted, taken_acc;
    logic [31:0]      target;
    logic             target_valid;

    branch_target_calc u_target (
        .instruction  (bus.ID_Instruction),
        .pc_plus4     (bus.ID_PCPlus4),
        .target       (target),
        .target_valid (target_valid)
    );

    assign accepted  = bus.BranchValid & ~bus.Stall & (state_q == RUN);
    assign taken_acc = accepted & bus.BranchTaken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        err_d      = err_q;
        flush_c    = 1'b0;
        redirect_c = 1'b0;
        if (state_q == RUN) begin
            if (taken_acc && target_valid) begin
                flush_c = 1'b1;
                if (bus.IMemReady) begin
                    redirect_c = 1'b1;
                    pc_d       = target;
                end else begin
                    pend_d  = target;
                    state_d = PEND;
                end
            end else if (!bus.Stall && bus.IMemReady) begin
                pc_d = pc_q + 32'd4;
            end
            // Taken with an opcode that has no target: fall through as not-taken, flag it.
            if (taken_acc && !target_valid) err_d = 1'b1;
        end else begin
            // The fetch at pc_q is still in flight; ID only sees bubbles until it completes.
            flush_c = 1'b1;
            if (bus.BranchValid) err_d = 1'b1;
            if (bus.IMemReady) begin
                redirect_c = 1'b1;
                pc_d       = pend_q;
                state_d    = RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            err_q    <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            if (accepted && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (taken_acc && (tk_cnt_q != '1)) tk_cnt_q <= tk_cnt_q + CNT_W'(1);
        end
    end

    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_q + 32'd4;
    assign bus.Flush_IFID  = flush_c & Rst_n;
    assign bus.Redirect    = redirect_c & Rst_n;
    assign bus.BranchCount = br_cnt_q;
    assign bus.TakenCount  = tk_cnt_q;
    assign bus.Err         = err_q;
    assign bus.State       = state_q;

endmodule
